// File: rtl/ifft_if.sv
// ifft_if: streaming bin-in / sample-out handshake bundle for the ifft block.
// master drives the input stream and out_ready; slave is the transform itself.
interface ifft_if #(
    parameter int DW = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_real;
    logic signed [DW-1:0] in_imag;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_real;
    logic signed [DW-1:0] out_imag;
    logic                 out_last;
    logic                 busy;

    modport master (
        output in_valid, in_real, in_imag, out_ready,
        input  in_ready, out_valid, out_real, out_imag, out_last, busy
    );

    modport slave (
        input  in_valid, in_real, in_imag, out_ready,
        output in_ready, out_valid, out_real, out_imag, out_last, busy
    );
endinterface

// File: rtl/ifft.sv
// ifft: iterative radix-2 DIT inverse FFT, in-place buffer, one butterfly per clock, 1/2 scale per stage.
// Define IFFT_ROUND_EN for round-half-up on every shift; the default build truncates.
module ifft #(
    parameter int DW = 16,
    parameter int N  = 64
) (
    input  logic  clk,
    input  logic  rst,
    ifft_if.slave bus
);
    localparam int LG = $clog2(N);
    localparam int PW = DW + 16;
    localparam int TW = DW + 2;
`ifdef IFFT_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif
    localparam logic signed [PW:0]   RND_P   = (PW+1)'(ROUND ? 16384 : 0);
    localparam logic signed [TW-1:0] RND_S   = TW'(ROUND ? 1 : 0);
    localparam logic [3:0]           ST_LAST = 4'(LG - 1);

    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;
    state_t state;

    logic signed [DW-1:0] mem_re [N];
    logic signed [DW-1:0] mem_im [N];

    logic [LG-1:0]        in_cnt, out_cnt, out_nxt;
    logic [LG-2:0]        b;
    logic [3:0]           st;
    logic                 in_ready_q, out_valid_q, out_last_q, busy_q;
    logic signed [DW-1:0] out_re_q, out_im_q;

    // Quarter-wave sine table, round(32767*sin(i*pi/128)), i = 0..64.
    function automatic logic [15:0] qrom(input logic [6:0] i);
        case (i)
            7'd0:  qrom = 16'd0;     7'd1:  qrom = 16'd804;   7'd2:  qrom = 16'd1608;  7'd3:  qrom = 16'd2410;
            7'd4:  qrom = 16'd3212;  7'd5:  qrom = 16'd4011;  7'd6:  qrom = 16'd4808;  7'd7:  qrom = 16'd5602;
            7'd8:  qrom = 16'd6393;  7'd9:  qrom = 16'd7179;  7'd10: qrom = 16'd7962;  7'd11: qrom = 16'd8739;
            7'd12: qrom = 16'd9512;  7'd13: qrom = 16'd10278; 7'd14: qrom = 16'd11039; 7'd15: qrom = 16'd11793;
            7'd16: qrom = 16'd12540; 7'd17: qrom = 16'd13279; 7'd18: qrom = 16'd14010; 7'd19: qrom = 16'd14733;
            7'd20: qrom = 16'd15446; 7'd21: qrom = 16'd16151; 7'd22: qrom = 16'd16846; 7'd23: qrom = 16'd17530;
            7'd24: qrom = 16'd18205; 7'd25: qrom = 16'd18868; 7'd26: qrom = 16'd19520; 7'd27: qrom = 16'd20160;
            7'd28: qrom = 16'd20787; 7'd29: qrom = 16'd21403; 7'd30: qrom = 16'd22005; 7'd31: qrom = 16'd22594;
            7'd32: qrom = 16'd23170; 7'd33: qrom = 16'd23732; 7'd34: qrom = 16'd24279; 7'd35: qrom = 16'd24812;
            7'd36: qrom = 16'd25329; 7'd37: qrom = 16'd25832; 7'd38: qrom = 16'd26319; 7'd39: qrom = 16'd26790;
            7'd40: qrom = 16'd27245; 7'd41: qrom = 16'd27684; 7'd42: qrom = 16'd28105; 7'd43: qrom = 16'd28510;
            7'd44: qrom = 16'd28898; 7'd45: qrom = 16'd29268; 7'd46: qrom = 16'd29621; 7'd47: qrom = 16'd29956;
            7'd48: qrom = 16'd30273; 7'd49: qrom = 16'd30572; 7'd50: qrom = 16'd30852; 7'd51: qrom = 16'd31113;
            7'd52: qrom = 16'd31356; 7'd53: qrom = 16'd31580; 7'd54: qrom = 16'd31785; 7'd55: qrom = 16'd31971;
            7'd56: qrom = 16'd32138; 7'd57: qrom = 16'd32285; 7'd58: qrom = 16'd32413; 7'd59: qrom = 16'd32521;
            7'd60: qrom = 16'd32610; 7'd61: qrom = 16'd32679; 7'd62: qrom = 16'd32728; 7'd63: qrom = 16'd32757;
            default: qrom = 16'd32767;
        endcase
    endfunction

    function automatic logic signed [15:0] sin_q(input logic [7:0] idx);
        logic [6:0] p;
        p     = idx[6] ? 7'd64 - {1'b0, idx[5:0]} : {1'b0, idx[5:0]};
        sin_q = idx[7] ? -$signed(qrom(p)) : $signed(qrom(p));
    endfunction

    function automatic logic [LG-1:0] bitrev(input logic [LG-1:0] v);
        bitrev = {<<{v}};
    endfunction

    logic [LG-1:0]        b_ext, half_i, k_i, m_i, p_i;
    logic [7:0]           ang;
    logic signed [15:0]   wc, ws;
    logic signed [DW-1:0] ur, ui, vr, vi;
    logic signed [PW:0]   tr_w, ti_w;
    logic signed [TW-1:0] tr, ti, sr, si, dr, di;
    logic signed [DW-1:0] top_re, top_im, bot_re, bot_im;

    // Butterfly datapath; sums carry two guard bits so full-scale complex inputs cannot wrap.
    always_comb begin
        b_ext  = {1'b0, b};
        half_i = LG'(1) << st;
        k_i    = b_ext & (half_i - LG'(1));
        m_i    = ((b_ext >> st) << (st + 4'd1)) | k_i;
        p_i    = m_i | half_i;
        ang    = 8'(k_i) << (4'd7 - st);
        wc     = sin_q(ang + 8'd64);
        ws     = sin_q(ang);
        ur     = mem_re[m_i];
        ui     = mem_im[m_i];
        vr     = mem_re[p_i];
        vi     = mem_im[p_i];
        tr_w   = (PW+1)'(vr) * (PW+1)'(wc) - (PW+1)'(vi) * (PW+1)'(ws) + RND_P;
        ti_w   = (PW+1)'(vr) * (PW+1)'(ws) + (PW+1)'(vi) * (PW+1)'(wc) + RND_P;
        tr     = TW'(tr_w >>> 15);
        ti     = TW'(ti_w >>> 15);
        sr     = TW'(ur) + tr + RND_S;
        si     = TW'(ui) + ti + RND_S;
        dr     = TW'(ur) - tr + RND_S;
        di     = TW'(ui) - ti + RND_S;
        top_re = DW'(sr >>> 1);
        top_im = DW'(si >>> 1);
        bot_re = DW'(dr >>> 1);
        bot_im = DW'(di >>> 1);
        out_nxt = out_cnt + LG'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst && state == LOAD && bus.in_valid && in_ready_q) begin
            mem_re[bitrev(in_cnt)] <= bus.in_real;
            mem_im[bitrev(in_cnt)] <= bus.in_imag;
        end else if (!rst && state == COMPUTE) begin
            mem_re[m_i] <= top_re;
            mem_im[m_i] <= top_im;
            mem_re[p_i] <= bot_re;
            mem_im[p_i] <= bot_im;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOAD;
            in_cnt      <= '0;
            out_cnt     <= '0;
            b           <= '0;
            st          <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (bus.in_valid && in_ready_q) begin
                        in_cnt <= in_cnt + 1'b1;
                        if (in_cnt == LG'(N - 1)) begin
                            state      <= COMPUTE;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    b <= b + 1'b1;
                    if (&b) begin
                        if (st == ST_LAST) begin
                            st    <= '0;
                            state <= UNLOAD;
                        end else begin
                            st <= st + 4'd1;
                        end
                    end
                end
                UNLOAD: begin
                    // First UNLOAD cycle only primes the output registers after the final butterfly write.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_re_q    <= mem_re[out_cnt];
                        out_im_q    <= mem_im[out_cnt];
                        out_last_q  <= (out_cnt == LG'(N - 1));
                    end else if (bus.out_ready) begin
                        if (out_last_q) begin
                            state       <= LOAD;
                            out_cnt     <= '0;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            out_re_q    <= '0;
                            out_im_q    <= '0;
                        end else begin
                            out_cnt    <= out_nxt;
                            out_re_q   <= mem_re[out_nxt];
                            out_im_q   <= mem_im[out_nxt];
                            out_last_q <= (out_nxt == LG'(N - 1));
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_real  = out_re_q;
    assign bus.out_imag  = out_im_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;
endmodule
